cpu4_core: RTL and testbench
============================

// Module: cpu4_core
// PURPOSE
//  Parametrised single-cycle accumulator CPU; successor to the 1-bit toggle core on the mother board.
//  Two registers (A, B), carry flag, program counter and output latch.
//  Fetches one instruction per enabled clock from external ROM (addr -> data) and executes it in
//  the same cycle. Drives out_port (LEDs) and reads in_port (switches).
// PARAMETERS
//  DW  4  data width of A, B, OUT, in_port and the immediate field
//  AW  4  program counter / ROM address width
// PORTS
//  clk       in   1      system clock, all state on rising edge
//  n_reset   in   1      asynchronous, active-low reset
//  en        in   1      clock enable; 0 = all state holds
//  addr      out  AW     ROM address = PC (combinational from PC register)
//  data      in   4+DW   instruction: data[DW+3:DW]=opcode, data[DW-1:0]=imm
//  in_port   in   DW     input switches, sampled by IN instructions
//  out_port  out  DW     output latch (LEDs)
//  carry     out  1      carry flag register
//  halted    out  1      1 = core stopped by HLT (constant 0 when CPU_HALT_EN undefined)
// BEHAVIOUR
//  Reset (async assert, sync release): A=0, B=0, C=0, PC=0, OUT=0, halted=0; addr=0.
//  Each rising edge with en=1 and halted=0 executes data; results visible next cycle. en=0: no change.
//  Adder: sum = {1'b0,src} + {1'b0,imm}, DW+1 bits; register gets sum[DW-1:0], C gets sum[DW].
//  Opcodes (dest <= value; C cleared by every executed opcode except ADD):
//   0000 ADD A,imm   A<=A+imm, C<=carry-out     0001 MOV A,B    A<=B
//   0010 IN  A       A<=in_port                 0011 MOV A,imm  A<=imm
//   0100 MOV B,A     B<=A                       0101 ADD B,imm  B<=B+imm, C<=carry-out
//   0110 IN  B       B<=in_port                 0111 MOV B,imm  B<=imm
//   1001 OUT B       OUT<=B                     1011 OUT imm    OUT<=imm
//   1110 JNC imm     PC<=imm if C==0 (C is pre-instruction value), else PC+1
//   1111 JMP imm     PC<=imm
//   1000,1010,1100,1101: NOP (PC+1, C<=0)
//  Non-jump: PC<=PC+1 modulo 2^AW (PC=2^AW-1 wraps to 0). Jump target = imm zero-extended (AW>DW)
//  or truncated to low AW bits (AW<DW).
//  ADD with src+imm = 2^DW exactly: result 0, C=1. JNC after such ADD falls through; following
//  instruction clears C.
//  Reset asserted mid-program: all registers clear immediately, independent of clk/en.
//  No handshake on ROM: data must be valid the cycle addr is presented (async ROM).
// CONFIGURATION
//  CPU_HALT_EN defined: opcode 1000 = HLT: PC, A, B, OUT hold, C<=0, halted<=1 on that edge; all
//   later edges ignored until n_reset. addr stays at HLT address.
//  CPU_HALT_EN undefined: 1000 is NOP; halted tied 0.
// TESTING
//  1 Reset: n_reset=0 with en=1, toggling clk -> A=B=OUT=0, C=0, addr=0, halted=0; release at
//    addr 0 executes data(0) on first edge.
//  2 Arithmetic: MOV A,7; ADD A,9 -> A=0, C=1; next NOP -> C=0; ADD B,3 twice from B=0 -> B=6, C=0.
//  3 Branch: C=1 then JNC 5 -> addr=next PC; C=0 then JNC 5 -> addr=5; JMP 15 -> addr=15,
//    next edge addr=0 (wrap).
//  4 I/O: in_port=0xA, IN B, OUT B -> out_port=0xA; OUT 3 -> out_port=3; MOV A,B -> A=0xA.
//  5 Enable: en=0 for 4 cycles mid-program -> addr/A/B/OUT/C frozen; en=1 resumes same instruction.
//  6 Async reset mid-program (PC=9, OUT=5) between clk edges -> all outputs 0 immediately;
//    with CPU_HALT_EN: HLT at addr 4 -> halted=1, addr stays 4 for 10 cycles until reset.

Source files
------------

// File: rtl/cpu4_core_if.sv
// Bus bundle for cpu4_core: asynchronous ROM port (addr/data) plus the switch and LED ports.
// The master side belongs to the core; the slave side belongs to the board (ROM, switches, LEDs).
interface cpu4_core_if #(
   parameter int DW = 4,
   parameter int AW = 4
);
   logic [AW-1:0]   addr;
   logic [DW+3:0]   data;
   logic [DW-1:0]   in_port;
   logic [DW-1:0]   out_port;

   modport master (
      output addr,
      output out_port,
      input  data,
      input  in_port
   );

   modport slave (
      input  addr,
      input  out_port,
      output data,
      output in_port
   );
endinterface

// File: rtl/cpu4_core.sv
// Single-cycle accumulator CPU: A/B registers, carry, PC and LED latch, one instruction per enabled edge.
// Optional HLT instruction on opcode 1000 is enabled by defining CPU_HALT_EN.
module cpu4_core #(
   parameter int DW = 4,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          n_reset,
   input  logic          en,
   cpu4_core_if.master   bus,
   output logic          carry,
   output logic          halted
);

   localparam logic [3:0] OP_ADD_A  = 4'b0000;
   localparam logic [3:0] OP_MOV_AB = 4'b0001;
   localparam logic [3:0] OP_IN_A   = 4'b0010;
   localparam logic [3:0] OP_MOV_AI = 4'b0011;
   localparam logic [3:0] OP_MOV_BA = 4'b0100;
   localparam logic [3:0] OP_ADD_B  = 4'b0101;
   localparam logic [3:0] OP_IN_B   = 4'b0110;
   localparam logic [3:0] OP_MOV_BI = 4'b0111;
   localparam logic [3:0] OP_HLT    = 4'b1000;
   localparam logic [3:0] OP_OUT_B  = 4'b1001;
   localparam logic [3:0] OP_OUT_I  = 4'b1011;
   localparam logic [3:0] OP_JNC    = 4'b1110;
   localparam logic [3:0] OP_JMP    = 4'b1111;

   logic [DW-1:0] a_q, a_d;
   logic [DW-1:0] b_q, b_d;
   logic [DW-1:0] out_q, out_d;
   logic [AW-1:0] pc_q, pc_d;
   logic          c_q, c_d;

   logic [3:0]    opcode;
   logic [DW-1:0] imm;
   logic [DW:0]   sum_a;
   logic [DW:0]   sum_b;
   logic [AW-1:0] pc_inc;
   logic [AW-1:0] jump_target;
   logic          exec;

   assign opcode = bus.data[DW+3:DW];
   assign imm    = bus.data[DW-1:0];
   assign sum_a  = {1'b0, a_q} + {1'b0, imm};
   assign sum_b  = {1'b0, b_q} + {1'b0, imm};
   assign pc_inc = pc_q + AW'(1);

   // Immediate is zero-extended into a wider PC, or truncated into a narrower one.
   generate
      if (AW > DW) begin : g_target_zext
         assign jump_target = {{(AW-DW){1'b0}}, imm};
      end else begin : g_target_trunc
         assign jump_target = imm[AW-1:0];
      end
   endgenerate

`ifdef CPU_HALT_EN
   logic halted_q, halted_d;

   assign exec   = en & ~halted_q;
   assign halted = halted_q;
`else
   assign exec   = en;
   assign halted = 1'b0;
`endif

   always_comb begin
      a_d   = a_q;
      b_d   = b_q;
      out_d = out_q;
      c_d   = c_q;
      pc_d  = pc_q;
`ifdef CPU_HALT_EN
      halted_d = halted_q;
`endif
      if (exec) begin
         // Every executed opcode clears carry unless it is one of the two ADDs.
         c_d  = 1'b0;
         pc_d = pc_inc;
         case (opcode)
            OP_ADD_A: begin
               a_d = sum_a[DW-1:0];
               c_d = sum_a[DW];
            end
            OP_MOV_AB: a_d = b_q;
            OP_IN_A:   a_d = bus.in_port;
            OP_MOV_AI: a_d = imm;
            OP_MOV_BA: b_d = a_q;
            OP_ADD_B: begin
               b_d = sum_b[DW-1:0];
               c_d = sum_b[DW];
            end
            OP_IN_B:   b_d = bus.in_port;
            OP_MOV_BI: b_d = imm;
            OP_OUT_B:  out_d = b_q;
            OP_OUT_I:  out_d = imm;
            OP_JNC: begin
               if (!c_q) begin
                  pc_d = jump_target;
               end
            end
            OP_JMP:    pc_d = jump_target;
`ifdef CPU_HALT_EN
            OP_HLT: begin
               pc_d     = pc_q;
               halted_d = 1'b1;
            end
`endif
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         a_q   <= '0;
         b_q   <= '0;
         out_q <= '0;
         pc_q  <= '0;
         c_q   <= 1'b0;
      end else begin
         a_q   <= a_d;
         b_q   <= b_d;
         out_q <= out_d;
         pc_q  <= pc_d;
         c_q   <= c_d;
      end
   end

`ifdef CPU_HALT_EN
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         halted_q <= 1'b0;
      end else begin
         halted_q <= halted_d;
      end
   end
`endif

   assign bus.addr     = pc_q;
   assign bus.out_port = out_q;
   assign carry        = c_q;

endmodule

// File: tb/tb_cpu4_core.sv
// Directed and randomized checks of cpu4_core against an instruction-level reference model.
// Define CPU_HALT_EN for both bench and RTL to exercise the HLT instruction.
module tb_cpu4_core;

   logic clk;
   logic n_reset;
   logic en;
   logic carry;
   logic halted;
   logic [7:0] rom [16];

   int total;
   int bad;

   // Reference model state (plain integers, DW = AW = 4)
   int m_a, m_b, m_c, m_pc, m_out, m_halt;

   cpu4_core_if #(.DW(4), .AW(4)) bus ();

   cpu4_core #(.DW(4), .AW(4)) dut (
      .clk     (clk),
      .n_reset (n_reset),
      .en      (en),
      .bus     (bus),
      .carry   (carry),
      .halted  (halted)
   );

   assign bus.data = rom[bus.addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_state(input string tag);
      chk({tag, ".addr"},   {4'h0, bus.addr},     m_pc[7:0]);
      chk({tag, ".out"},    {4'h0, bus.out_port}, m_out[7:0]);
      chk({tag, ".carry"},  {7'h0, carry},        m_c[7:0]);
      chk({tag, ".halted"}, {7'h0, halted},       m_halt[7:0]);
      $display("cyc pc=%0d out=%0h c=%0d h=%0d [%s]", m_pc, m_out, m_c, m_halt, tag);
   endtask

   task automatic model_reset();
      m_a = 0; m_b = 0; m_c = 0; m_pc = 0; m_out = 0; m_halt = 0;
   endtask

   // One enabled edge of the architectural machine.
   task automatic model_exec(input int inp);
      int op, imm, nc, npc, s;
      op  = int'(rom[m_pc][7:4]);
      imm = int'(rom[m_pc][3:0]);
      nc  = 0;
      npc = (m_pc + 1) % 16;
      case (op)
         0:  begin s = m_a + imm; m_a = s % 16; nc = (s >= 16) ? 1 : 0; end
         1:  m_a = m_b;
         2:  m_a = inp;
         3:  m_a = imm;
         4:  m_b = m_a;
         5:  begin s = m_b + imm; m_b = s % 16; nc = (s >= 16) ? 1 : 0; end
         6:  m_b = inp;
         7:  m_b = imm;
         9:  m_out = m_b;
         11: m_out = imm;
         14: if (m_c == 0) npc = imm;
         15: npc = imm;
`ifdef CPU_HALT_EN
         8:  begin npc = m_pc; m_halt = 1; end
`endif
         default: ;
      endcase
      m_c  = nc;
      m_pc = npc;
   endtask

   task automatic step(input logic e, input string tag);
      en = e;
      @(posedge clk);
      if (e && (m_halt == 0)) model_exec(int'(bus.in_port));
      #1;
      check_state(tag);
   endtask

   task automatic load_nops();
      for (int i = 0; i < 16; i++) rom[i] = 8'hC0;
   endtask

   task automatic reset_core();
      en = 1'b1;
      n_reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      model_reset();
      check_state("reset");
      n_reset = 1'b1;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      en = 1'b0;
      n_reset = 1'b0;
      bus.in_port = 4'h0;
      load_nops();
      model_reset();

      // Arithmetic: carry out of exactly 2^DW, clear on next op, B accumulation
      rom[0] = 8'h37; rom[1] = 8'h09; rom[2] = 8'hC0; rom[3] = 8'h70;
      rom[4] = 8'h53; rom[5] = 8'h53; rom[6] = 8'h90; rom[7] = 8'h40; rom[8] = 8'h90;
      reset_core();
      chk("reset_addr", {4'h0, bus.addr}, 8'h00);
      step(1, "mov_a7");
      step(1, "add_a9");
      chk("add_wrap_carry", {7'h0, carry}, 8'h01);
      step(1, "nop");
      chk("nop_clears_c", {7'h0, carry}, 8'h00);
      step(1, "mov_b0");
      step(1, "add_b3");
      step(1, "add_b3b");
      step(1, "out_b");
      chk("b_is_6", {4'h0, bus.out_port}, 8'h06);
      step(1, "mov_ba");
      step(1, "out_b_a");
      chk("a_is_0", {4'h0, bus.out_port}, 8'h00);

      // Branch: JNC taken/not taken, JMP 15 and PC wrap
      load_nops();
      rom[0] = 8'h3F; rom[1] = 8'h01; rom[2] = 8'hE5; rom[3] = 8'hE5; rom[5] = 8'hFF;
      reset_core();
      step(1, "mov_af");
      step(1, "add_a1");
      step(1, "jnc_c1");
      chk("jnc_fallthru", {4'h0, bus.addr}, 8'h03);
      step(1, "jnc_c0");
      chk("jnc_taken", {4'h0, bus.addr}, 8'h05);
      step(1, "jmp15");
      chk("jmp_15", {4'h0, bus.addr}, 8'h0F);
      step(1, "wrap");
      chk("pc_wrap", {4'h0, bus.addr}, 8'h00);

      // I/O plus clock-enable freeze in the middle
      load_nops();
      rom[0] = 8'h60; rom[1] = 8'h90; rom[2] = 8'hB3; rom[3] = 8'h10;
      rom[4] = 8'h70; rom[5] = 8'h90; rom[6] = 8'h40; rom[7] = 8'h90;
      reset_core();
      bus.in_port = 4'hA;
      step(1, "in_b");
      step(1, "out_b");
      chk("out_in_a", {4'h0, bus.out_port}, 8'h0A);
      step(1, "out_3");
      chk("out_imm3", {4'h0, bus.out_port}, 8'h03);
      bus.in_port = 4'h5;
      for (int i = 0; i < 4; i++) step(0, "en_off");
      chk("frozen_addr", {4'h0, bus.addr}, 8'h03);
      step(1, "mov_ab");
      step(1, "mov_b0");
      step(1, "out_b0");
      step(1, "mov_ba");
      step(1, "out_b_a");
      chk("a_is_a", {4'h0, bus.out_port}, 8'h0A);

      // Asynchronous reset between edges at PC=9, OUT=5
      load_nops();
      rom[0] = 8'hB5;
      reset_core();
      for (int i = 0; i < 9; i++) step(1, "run");
      chk("pre_rst_pc", {4'h0, bus.addr}, 8'h09);
      chk("pre_rst_out", {4'h0, bus.out_port}, 8'h05);
      #2;
      n_reset = 1'b0;
      #1;
      model_reset();
      check_state("async_rst");
      @(posedge clk);
      #1;
      n_reset = 1'b1;

`ifdef CPU_HALT_EN
      load_nops();
      rom[4] = 8'h80;
      reset_core();
      for (int i = 0; i < 5; i++) step(1, "to_hlt");
      chk("halted_set", {7'h0, halted}, 8'h01);
      for (int i = 0; i < 10; i++) step(1, "halted");
      chk("hlt_addr", {4'h0, bus.addr}, 8'h04);
`endif

      // Randomized programs, enables and switch inputs
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
         reset_core();
         for (int c = 0; c < 150; c++) begin
            bus.in_port = 4'($urandom);
            step(($urandom_range(0, 3) != 0), "rand");
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
